// File: rtl/mem_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : mem_timing_pkg                                         |
// | Description : Shared widths, counter sizing helper and phase-train   |
// |               bundle type for the LVDC memory timing generator.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mem_timing_pkg;

   // Default pulse widths in clocks at 100 MHz (2500 ns and 1500 ns).
   localparam int P2_CYC_DEF = 250;
   localparam int P3_CYC_DEF = 150;

   // Counter width able to hold the value 'width'.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   // One three-phase pulse train (read or store).
   typedef struct packed {
      logic p1;
      logic p2;
      logic p3;
   } phase_t;

endpackage : mem_timing_pkg
`default_nettype wire

// File: rtl/mcd_oneshot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mcd_oneshot                                            |
// | Description : Falling-edge one-shot. A 1->0 transition on 'a' makes  |
// |               'y' high for exactly WIDTH cycles, starting in the     |
// |               same cycle in which 'a' is first seen low.             |
// | Options     : MCD_RETRIGGER_EN - a trigger while active reloads the  |
// |               counter; otherwise such a trigger is dropped.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mcd_oneshot
   import mem_timing_pkg::*;
#(
   parameter int WIDTH = P2_CYC_DEF   // pulse width in clocks, must be >= 1
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   output logic y
);

   localparam int            CW     = cnt_w(WIDTH);
   // The trigger cycle itself is covered by 'fire', so the counter only
   // has to account for the remaining WIDTH-1 cycles.
   localparam logic [CW-1:0] RELOAD = CW'(WIDTH - 1);

   logic          a_prev_q, a_prev_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fire;
   logic          active;

   // Edge detect, counter update and output; 'y' is combinational so the
   // pulse abuts the end of the driving pulse with no gap cycle.
   always_comb begin
      fire     = a_prev_q & ~a;
      active   = (cnt_q != '0);
      a_prev_d = a;
      cnt_d    = cnt_q;
      if (active) begin
         cnt_d = cnt_q - 1'b1;
      end
`ifdef MCD_RETRIGGER_EN
      if (fire) begin
         cnt_d = RELOAD;
      end
`else
      if (fire && !active) begin
         cnt_d = RELOAD;
      end
`endif
      y = fire | active;
   end

   // State register: previous input sample and remaining-width counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_prev_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         a_prev_q <= a_prev_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule : mcd_oneshot
`default_nettype wire

// File: rtl/mem_read_timing.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_read_timing                                        |
// | Description : Read/store timing-pulse generator for one LVDC memory  |
// |               module: three-phase read and store pulse trains, gated |
// |               sense strobe and X/Y error-detect enables.             |
// | Options     : MCD_RETRIGGER_EN - phase-2/3 one-shots re-trigger on a |
// |               new edge while active (see mcd_oneshot).               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_read_timing
   import mem_timing_pkg::*;
#(
   parameter int P2_CYC = P2_CYC_DEF,   // phase-2 width in clocks, >= 1
   parameter int P3_CYC = P3_CYC_DEF    // phase-3 width in clocks, >= 1
) (
   input  logic clk,
   input  logic rst,
   input  logic MmSYNCV,
   input  logic AnRDMV,
   input  logic AnRDMVN,
   input  logic AnINHBSV,
   output logic MmRDP1,
   output logic MmRDP2,
   output logic MmRDP3,
   output logic MmSTRP1,
   output logic MmSTRP2,
   output logic MmSTRP3,
   output logic MmSTROB,
   output logic EDmX,
   output logic EDmY
);

   logic   rdp1_q, rdp1_d;
   logic   strp1_q, strp1_d;
   logic   rdp2, rdp3;
   logic   strp2, strp3;
   phase_t rd_ph, st_ph;

   // Phase 1: sync qualified by read or write mode.
   always_comb begin
      rdp1_d  = MmSYNCV & AnRDMV;
      strp1_d = AnRDMVN & MmSYNCV;
   end

   // Phase-1 registers; reset overrides any request on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdp1_q  <= 1'b0;
         strp1_q <= 1'b0;
      end else begin
         rdp1_q  <= rdp1_d;
         strp1_q <= strp1_d;
      end
   end

   // Read chain: RDP1 -> RDP2 -> RDP3.
   mcd_oneshot #(.WIDTH(P2_CYC)) u_rdp2 (
      .clk (clk),
      .rst (rst),
      .a   (rdp1_q),
      .y   (rdp2)
   );

   mcd_oneshot #(.WIDTH(P3_CYC)) u_rdp3 (
      .clk (clk),
      .rst (rst),
      .a   (rdp2),
      .y   (rdp3)
   );

   // Store chain: STRP1 -> STRP2 -> STRP3, independent of the read chain.
   mcd_oneshot #(.WIDTH(P2_CYC)) u_strp2 (
      .clk (clk),
      .rst (rst),
      .a   (strp1_q),
      .y   (strp2)
   );

   mcd_oneshot #(.WIDTH(P3_CYC)) u_strp3 (
      .clk (clk),
      .rst (rst),
      .a   (strp2),
      .y   (strp3)
   );

   // Output stage: pulse trains, gated strobe and error-detect enables.
   always_comb begin
      rd_ph   = '{p1: rdp1_q,  p2: rdp2,  p3: rdp3};
      st_ph   = '{p1: strp1_q, p2: strp2, p3: strp3};
      MmRDP1  = rd_ph.p1;
      MmRDP2  = rd_ph.p2;
      MmRDP3  = rd_ph.p3;
      MmSTRP1 = st_ph.p1;
      MmSTRP2 = st_ph.p2;
      MmSTRP3 = st_ph.p3;
      MmSTROB = rd_ph.p3 & ~AnINHBSV;
      EDmX    = rd_ph.p3 | st_ph.p3;
      EDmY    = rd_ph.p3 | st_ph.p3;
   end

endmodule : mem_read_timing
`default_nettype wire

// File: tb/tb_mem_read_timing.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_read_timing                                     |
// | Description : Directed self-checking bench for mem_read_timing with  |
// |               P2_CYC=4, P3_CYC=3. Expected output vectors are queued |
// |               per cycle and compared against the DUT outputs.        |
// | Options     : MCD_RETRIGGER_EN selects the re-trigger expectation.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mem_read_timing;

   localparam int P2 = 4;
   localparam int P3 = 3;
`ifdef MCD_RETRIGGER_EN
   localparam int RT_R2 = 6;
`else
   localparam int RT_R2 = 4;
`endif

   logic clk = 1'b0;
   logic rst;
   logic sync, rdmv, rdmvn, inhb;
   logic rdp1, rdp2, rdp3, strp1, strp2, strp3, strob, edx, edy;

   logic [8:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   mem_read_timing #(.P2_CYC(P2), .P3_CYC(P3)) dut (
      .clk      (clk),
      .rst      (rst),
      .MmSYNCV  (sync),
      .AnRDMV   (rdmv),
      .AnRDMVN  (rdmvn),
      .AnINHBSV (inhb),
      .MmRDP1   (rdp1),
      .MmRDP2   (rdp2),
      .MmRDP3   (rdp3),
      .MmSTRP1  (strp1),
      .MmSTRP2  (strp2),
      .MmSTRP3  (strp3),
      .MmSTROB  (strob),
      .EDmX     (edx),
      .EDmY     (edy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         if (edx !== edy) begin
            errors++;
            $error("FAIL comb: EDmX %b differs from EDmY %b", edx, edy);
         end
         if (edx !== (rdp3 | strp3)) begin
            errors++;
            $error("FAIL comb: EDmX %b expected %b", edx, rdp3 | strp3);
         end
         if (strob !== (rdp3 & ~inhb)) begin
            errors++;
            $error("FAIL comb: MmSTROB %b expected %b", strob, rdp3 & ~inhb);
         end
      end
   end

   function automatic logic span(input int j, input int s, input int l);
      return (j >= s) && (j < s + l);
   endfunction

   // Expected vector {RDP1..3, STRP1..3, STROB, EDX, EDY} for window j of a
   // train whose phase 1 starts in window r1s/s1s and lasts r1l/s1l.
   function automatic logic [8:0] train_vec(input int j,
                                            input int r1s, input int r1l,
                                            input int r2l, input int r3l,
                                            input int s1s, input int s1l,
                                            input int s2l, input int s3l,
                                            input logic inh);
      logic r1, r2, r3, s1, s2, s3;
      r1 = span(j, r1s, r1l);
      r2 = span(j, r1s + r1l, r2l);
      r3 = span(j, r1s + r1l + r2l, r3l);
      s1 = span(j, s1s, s1l);
      s2 = span(j, s1s + s1l, s2l);
      s3 = span(j, s1s + s1l + s2l, s3l);
      return {r1, r2, r3, s1, s2, s3, r3 & ~inh, r3 | s3, r3 | s3};
   endfunction

   // One clock window: drive inputs (sampled at the closing edge; INHBSV
   // acts within the window), compare against the queued expectation.
   task automatic run_window(input logic r, input logic s, input logic rm,
                             input logic wm, input logic ih, input string tag);
      logic [8:0] o, e;
      rst   = r;
      sync  = s;
      rdmv  = rm;
      rdmvn = wm;
      inhb  = ih;
      #1;
      o = {rdp1, rdp2, rdp3, strp1, strp2, strp3, strob, edx, edy};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %b, expected entry missing from queue", tag, o);
      end else begin
         e = exp_q.pop_front();
         assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [8:0] v;
      logic       r3;

      // Reset held with every input high, then released with inputs low.
      rst = 1'b1; sync = 1'b1; rdmv = 1'b1; rdmvn = 1'b1; inhb = 1'b1;
      @(posedge clk);
      #1;
      for (int j = 0; j < 3; j++) begin
         exp_q.push_back(9'b0);
         run_window(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "reset_hold");
      end
      for (int j = 0; j < 3; j++) begin
         exp_q.push_back(9'b0);
         run_window(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_release");
      end

      // Read train: request for 2 clocks -> RDP1 2, RDP2 4, RDP3 3.
      for (int j = 0; j < 12; j++) begin
         exp_q.push_back(train_vec(j, 1, 2, P2, P3, 0, 0, 0, 0, 1'b0));
         run_window(1'b0, j < 2, j < 2, 1'b0, 1'b0, "read_train");
      end

      // Strobe gating: inhibit during the first two RDP3 cycles.
      for (int j = 0; j < 12; j++) begin
         exp_q.push_back(train_vec(j, 1, 2, P2, P3, 0, 0, 0, 0, (j == 7) || (j == 8)));
         run_window(1'b0, j < 2, j < 2, 1'b0, (j == 7) || (j == 8), "strobe_gate");
      end

      // Store train: one-clock write request -> STRP 1/4/3, RDP idle.
      for (int j = 0; j < 11; j++) begin
         exp_q.push_back(train_vec(j, 0, 0, 0, 0, 1, 1, P2, P3, 1'b0));
         run_window(1'b0, j < 1, 1'b0, j < 1, 1'b0, "store_train");
      end

      // Simultaneous read and write: both trains run side by side.
      for (int j = 0; j < 11; j++) begin
         exp_q.push_back(train_vec(j, 1, 1, P2, P3, 1, 1, P2, P3, 1'b0));
         run_window(1'b0, j < 1, j < 1, j < 1, 1'b0, "both_trains");
      end

      // Re-trigger: second RDP1 pulse while RDP2 is in its second cycle.
      for (int j = 0; j < 13; j++) begin
         r3 = span(j, 2 + RT_R2, P3);
         v  = {span(j, 1, 1) | span(j, 3, 1), span(j, 2, RT_R2), r3,
               1'b0, 1'b0, 1'b0, r3, r3, r3};
         exp_q.push_back(v);
         run_window(1'b0, (j == 0) || (j == 2), (j == 0) || (j == 2), 1'b0, 1'b0,
                    "retrigger");
      end

      // Mid-pulse reset during RDP2: everything clears, no RDP3 follows.
      for (int j = 0; j < 13; j++) begin
         if (j < 5) begin
            exp_q.push_back(train_vec(j, 1, 2, P2, P3, 0, 0, 0, 0, 1'b0));
         end else begin
            exp_q.push_back(9'b0);
         end
         run_window(j == 4, j < 2, j < 2, 1'b0, 1'b0, "mid_reset");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mem_read_timing
`default_nettype wire
